sha256_msg_sched: RTL and testbench

- Producer side of the per-round Kt/Wt interface consumed by the SHA-256 compression core.
- Accepts one padded 512-bit message block through a valid/ready handshake.
- Pulses the core's load strobe, then streams 64 round words Wt plus the matching round constant Kt, one per accepted cycle.
- Sits between block padding/buffering and hash_core. Computes W16..W63 on the fly with a 16-word sliding window and holds Kt in an internal 64-entry constant table.

---
 rtl/sha256_msg_sched.sv | 140 ++++++++++++++
 tb/tb_sha256_msg_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// Message scheduler feeding the SHA-256 compression core. It takes one padded
// 512-bit block via a valid/ready handshake, pulses the core's load strobe for
// one cycle, then streams the 64 round words Wt with their round constants Kt.
// W16..W63 are generated on the fly from a 16-word sliding window.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   blk_valid_i  block_i holds a valid padded block
//   blk_ready_o  scheduler can accept a block
//   block_i      padded block, W0 in [511:480] ... W15 in [31:0]
//   load_o       one-cycle load strobe to the compression core
//   wt_valid_o   Wt_o/Kt_o/round_o are valid
//   wt_ready_i   consumer accepts the current round word
//   Wt_o         message schedule word for round_o
//   Kt_o         round constant K[round_o]
//   round_o      current round index 0..63
//   last_o       high with wt_valid_o on round 63
//   busy_o       high while loading or streaming
module sha256_msg_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic [511:0] block_i,
   output logic         load_o,
   output logic         wt_valid_o,
   input  logic         wt_ready_i,
   output logic [31:0]  Wt_o,
   output logic [31:0]  Kt_o,
   output logic [5:0]   round_o,
   output logic         last_o,
   output logic         busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [1:0]  state_q, state_d;
   logic [5:0]  round_q, round_d;
   logic [31:0] w_q [16];
   logic [31:0] w_d [16];
   logic        armed_q;
   logic [31:0] wNext;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Next-state logic. The window w_q always holds W[t..t+15] for the round t
   // being presented, so each accepted round shifts by one and appends
   // W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t].
   // A stalled round (wt_ready_i low) leaves every register untouched.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      for (int i = 0; i < 16; i++) begin
         w_d[i] = w_q[i];
      end
      wNext = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
      case (state_q)
         IDLE: begin
            if (blk_valid_i && blk_ready_o) begin
               for (int i = 0; i < 16; i++) begin
                  w_d[i] = block_i[511 - 32*i -: 32];
               end
               round_d = 6'd0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (wt_ready_i) begin
               for (int i = 0; i < 15; i++) begin
                  w_d[i] = w_q[i+1];
               end
               w_d[15] = wNext;
               round_d = round_q + 6'd1;
               if (round_q == 6'd63) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. armed_q keeps blk_ready_o low through the reset cycle
   // and releases it on the first clock edge that sees reset deasserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         round_q <= 6'd0;
         armed_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         armed_q <= 1'b1;
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= w_d[i];
         end
      end
   end

   // Outputs come straight from registers; Wt/Kt are forced to zero outside
   // RUN so an idle scheduler never shows a stale window word or K[0].
   assign blk_ready_o = (state_q == IDLE) && armed_q;
   assign load_o      = (state_q == LOAD);
   assign wt_valid_o  = (state_q == RUN);
   assign busy_o      = (state_q == LOAD) || (state_q == RUN);
   assign Wt_o        = wt_valid_o ? w_q[0] : 32'd0;
   assign Kt_o        = wt_valid_o ? K_TABLE[round_q] : 32'd0;
   assign round_o     = round_q;
   assign last_o      = wt_valid_o && (round_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched
// Scoreboard bench for sha256_msg_sched. Each issued block pushes its 64
// expected round words into a queue; a monitor compares every valid output
// cycle against the queue head and pops on acceptance. The accepted "abc"
// stream is also run through a compression model to reach the known digest.
module tb_sha256_msg_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid_i;
   logic         blk_ready_o;
   logic [511:0] block_i;
   logic         load_o;
   logic         wt_valid_o;
   logic         wt_ready_i;
   logic [31:0]  Wt_o;
   logic [31:0]  Kt_o;
   logic [5:0]   round_o;
   logic         last_o;
   logic         busy_o;

   typedef struct {
      logic [31:0] wt;
      logic [31:0] kt;
      logic [5:0]  round;
      logic        last;
   } expT;

   expT sbQ[$];
   int compared = 0;
   int mismatched = 0;
   int validCount = 0;
   int loadCount = 0;
   int busyReadyCount = 0;
   int readyMode = 0;
   int stall5Left = 0;
   int stall63Left = 0;
   bit hashEn = 1'b0;
   int hashRounds = 0;
   logic [31:0] ha, hb, hc, hd, he, hf, hg, hh;
   logic [31:0] seenWt [64];
   logic [31:0] seenKt [64];
   logic        seenLast [64];

   logic [31:0] kTab [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'd0, 32'h00000018};
   localparam logic [511:0] ALT_BLOCK = {8{64'h0123456789abcdef}};

   sha256_msg_sched dut (
      .clk         (clk),
      .rst         (rst),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .block_i     (block_i),
      .load_o      (load_o),
      .wt_valid_o  (wt_valid_o),
      .wt_ready_i  (wt_ready_i),
      .Wt_o        (Wt_o),
      .Kt_o        (Kt_o),
      .round_o     (round_o),
      .last_o      (last_o),
      .busy_o      (busy_o)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] smallS0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] smallS1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] bigS0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bigS1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: wait expired, got timeout, expected DUT event", name);
   endtask

   // Full 64-word schedule computed with the textbook index recurrence.
   task automatic pushExpected(input logic [511:0] blk);
      logic [31:0] w [64];
      expT e;
      for (int t = 0; t < 16; t++) begin
         w[t] = blk[511 - 32*t -: 32];
      end
      for (int t = 16; t < 64; t++) begin
         w[t] = smallS1(w[t-2]) + w[t-7] + smallS0(w[t-15]) + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         e.wt = w[t];
         e.kt = kTab[t];
         e.round = 6'(t);
         e.last = (t == 63);
         sbQ.push_back(e);
      end
   endtask

   // One compression round on the words the DUT actually handed over.
   task automatic hashRound(input logic [31:0] wt, input logic [31:0] kt);
      logic [31:0] t1, t2;
      t1 = hh + bigS1(he) + ((he & hf) ^ (~he & hg)) + kt + wt;
      t2 = bigS0(ha) + ((ha & hb) ^ (ha & hc) ^ (hb & hc));
      hh = hg; hg = hf; hf = he; he = hd + t1;
      hd = hc; hc = hb; hb = ha; ha = t1 + t2;
      hashRounds++;
   endtask

   // Monitor: every valid cycle is compared against the queue head, so a
   // stalled round must keep showing the same word; the head is popped only
   // when the consumer accepts it.
   always @(negedge clk) begin
      if (load_o === 1'b1) loadCount++;
      if (busy_o === 1'b1 && blk_ready_o === 1'b1) busyReadyCount++;
      if (wt_valid_o === 1'b1) begin
         validCount++;
         compared++;
         if (sbQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL sb_unexpected: got round=%0d Wt=%h, expected no valid output", round_o, Wt_o);
         end else begin
            if (Wt_o !== sbQ[0].wt || Kt_o !== sbQ[0].kt || round_o !== sbQ[0].round || last_o !== sbQ[0].last) begin
               mismatched++;
               $display("[TB] FAIL sb_round: got Wt=%h Kt=%h round=%0d last=%b, expected Wt=%h Kt=%h round=%0d last=%b",
                        Wt_o, Kt_o, round_o, last_o, sbQ[0].wt, sbQ[0].kt, sbQ[0].round, sbQ[0].last);
            end
            if (wt_ready_i) begin
               void'(sbQ.pop_front());
               seenWt[round_o] = Wt_o;
               seenKt[round_o] = Kt_o;
               seenLast[round_o] = last_o;
               if (hashEn) hashRound(Wt_o, Kt_o);
            end
         end
      end
   end

   // Consumer model: always ready, a fixed stall pattern (3 cycles at round
   // 5, 1 cycle at round 63), or random back-pressure.
   always @(posedge clk) begin
      #1;
      if (load_o === 1'b1) begin
         stall5Left = 3;
         stall63Left = 1;
      end
      case (readyMode)
         1: begin
            if (wt_valid_o === 1'b1 && round_o == 6'd5 && stall5Left > 0) begin
               wt_ready_i = 1'b0;
               stall5Left--;
            end else if (wt_valid_o === 1'b1 && round_o == 6'd63 && stall63Left > 0) begin
               wt_ready_i = 1'b0;
               stall63Left--;
            end else begin
               wt_ready_i = 1'b1;
            end
         end
         2: wt_ready_i = ($urandom_range(0, 3) != 0);
         default: wt_ready_i = 1'b1;
      endcase
   end

   // Issues one block and waits for the scheduler to become ready again.
   // With holdNext set, blk_valid_i stays high carrying nextBlk while busy.
   task automatic applyStimulus(input logic [511:0] blk, input int mode, input bit checkTiming,
                                input bit holdNext, input logic [511:0] nextBlk);
      int n;
      int l0;
      int v0;
      readyMode = mode;
      n = 0;
      while (blk_ready_o !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (blk_ready_o !== 1'b1) begin
         timeoutFail("wait_ready_before");
         return;
      end
      pushExpected(blk);
      l0 = loadCount;
      v0 = validCount;
      blk_valid_i = 1'b1;
      block_i = blk;
      @(posedge clk);
      #1;
      checkOutput("load_after_accept", 256'(load_o), 256'd1);
      checkOutput("busy_in_load", 256'(busy_o), 256'd1);
      if (holdNext) block_i = nextBlk;
      else blk_valid_i = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (blk_ready_o !== 1'b1 && n < 2000);
      if (blk_ready_o !== 1'b1) begin
         timeoutFail("wait_ready_after");
         return;
      end
      if (checkTiming) checkOutput("ready_return_cycle", 256'(n), 256'd66);
      checkOutput("sb_drained", 256'(sbQ.size()), 256'd0);
      checkOutput("load_pulses", 256'(loadCount - l0), 256'd1);
      if (mode != 2) checkOutput("valid_cycles", 256'(validCount - v0), (mode == 1) ? 256'd68 : 256'd64);
   endtask

   task automatic checkResetOutputs(input logic expReady);
      checkOutput("rst_blk_ready", 256'(blk_ready_o), 256'(expReady));
      checkOutput("rst_wt_valid", 256'(wt_valid_o), 256'd0);
      checkOutput("rst_busy", 256'(busy_o), 256'd0);
      checkOutput("rst_load", 256'(load_o), 256'd0);
      checkOutput("rst_last", 256'(last_o), 256'd0);
      checkOutput("rst_round", 256'(round_o), 256'd0);
      checkOutput("rst_wt", 256'(Wt_o), 256'd0);
      checkOutput("rst_kt", 256'(Kt_o), 256'd0);
   endtask

   // Streams a block, pulls reset while round 30 is on the outputs, and
   // checks the scheduler comes back idle and ready.
   task automatic resetMidRun(input logic [511:0] blk);
      int n;
      readyMode = 0;
      n = 0;
      while (blk_ready_o !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      pushExpected(blk);
      blk_valid_i = 1'b1;
      block_i = blk;
      @(posedge clk);
      #1;
      blk_valid_i = 1'b0;
      n = 0;
      while (!(wt_valid_o === 1'b1 && round_o == 6'd30) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!(wt_valid_o === 1'b1 && round_o == 6'd30)) begin
         timeoutFail("wait_round30");
         return;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      sbQ.delete();
      checkResetOutputs(1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", 256'(blk_ready_o), 256'd1);
   endtask

   initial begin
      logic [511:0] rblk;
      logic [255:0] digest;
      rst = 1'b1;
      blk_valid_i = 1'b0;
      block_i = '0;
      wt_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs(1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_init", 256'(blk_ready_o), 256'd1);

      $display("[TB] abc block, consumer always ready");
      ha = 32'h6a09e667; hb = 32'hbb67ae85; hc = 32'h3c6ef372; hd = 32'ha54ff53a;
      he = 32'h510e527f; hf = 32'h9b05688c; hg = 32'h1f83d9ab; hh = 32'h5be0cd19;
      hashRounds = 0;
      for (int i = 0; i < 64; i++) begin
         seenWt[i] = '0;
         seenKt[i] = '0;
         seenLast[i] = 1'b0;
      end
      hashEn = 1'b1;
      applyStimulus(ABC_BLOCK, 0, 1'b1, 1'b0, '0);
      hashEn = 1'b0;
      checkOutput("abc_w0", 256'(seenWt[0]), 256'h61626380);
      checkOutput("abc_k0", 256'(seenKt[0]), 256'h428a2f98);
      checkOutput("abc_w16", 256'(seenWt[16]), 256'h61626380);
      checkOutput("abc_w17", 256'(seenWt[17]), 256'h000f0000);
      checkOutput("abc_k63", 256'(seenKt[63]), 256'hc67178f2);
      checkOutput("abc_last63", 256'(seenLast[63]), 256'd1);
      checkOutput("abc_last62", 256'(seenLast[62]), 256'd0);
      checkOutput("abc_hash_rounds", 256'(hashRounds), 256'd64);
      digest = {ha + 32'h6a09e667, hb + 32'hbb67ae85, hc + 32'h3c6ef372, hd + 32'ha54ff53a,
                he + 32'h510e527f, hf + 32'h9b05688c, hg + 32'h1f83d9ab, hh + 32'h5be0cd19};
      checkOutput("abc_digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

      $display("[TB] abc block with consumer stalls");
      applyStimulus(ABC_BLOCK, 1, 1'b0, 1'b0, '0);

      $display("[TB] second block offered while busy");
      busyReadyCount = 0;
      applyStimulus(ABC_BLOCK, 0, 1'b1, 1'b1, ALT_BLOCK);
      applyStimulus(ALT_BLOCK, 0, 1'b1, 1'b0, '0);
      checkOutput("ready_while_busy", 256'(busyReadyCount), 256'd0);

      $display("[TB] reset during round 30");
      resetMidRun(ALT_BLOCK);
      applyStimulus(ABC_BLOCK, 0, 1'b1, 1'b0, '0);

      $display("[TB] random blocks with random back-pressure");
      for (int b = 0; b < 200; b++) begin
         for (int j = 0; j < 16; j++) begin
            rblk[511 - 32*j -: 32] = $urandom();
         end
         applyStimulus(rblk, 2, 1'b0, 1'b0, '0);
      end
      checkOutput("ready_while_busy_all", 256'(busyReadyCount), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
